// File: rtl/execute_muldiv_stage_pkg.sv
// Shared definitions for the execute-stage RV32M unit: funct3 op codes,
// FSM state encoding and the fixed results of the special divide cases.
package execute_muldiv_stage_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] RES_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] RES_INT_MIN  = 32'h8000_0000;

  // Two's-complement negation used for magnitudes and sign fix-up.
  function automatic logic [31:0] negate32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/execute_muldiv_stage_divider.sv
// Iterative unsigned restoring divider. The first step is taken on the start
// edge using the fresh operands, so quotient/remainder are valid (done = 1)
// exactly 32 cycles after start.
module muldiv_divider
  import execute_muldiv_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [5:0]  cnt_r;
  logic        busy_r;
  logic        done_r;

  logic [31:0] src_rem_s;
  logic [31:0] src_quo_s;
  logic [31:0] src_dvs_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic [31:0] nxt_rem_s;
  logic [31:0] nxt_quo_s;

  // One restoring step, fed by the new operands on start or the running state otherwise.
  always_comb begin
    if (start) begin
      src_rem_s = 32'd0;
      src_quo_s = dividend;
      src_dvs_s = divisor;
    end else begin
      src_rem_s = rem_r;
      src_quo_s = quo_r;
      src_dvs_s = dvs_r;
    end
    shifted_s = {src_rem_s, src_quo_s[31]};
    diff_s    = shifted_s - {1'b0, src_dvs_s};
    if (diff_s[32]) begin
      nxt_rem_s = shifted_s[31:0];
      nxt_quo_s = {src_quo_s[30:0], 1'b0};
    end else begin
      nxt_rem_s = diff_s[31:0];
      nxt_quo_s = {src_quo_s[30:0], 1'b1};
    end
  end

  // Iteration state: counter tracks completed steps, done pulses after the 32nd.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= 32'd0;
      quo_r  <= 32'd0;
      dvs_r  <= 32'd0;
      cnt_r  <= 6'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= nxt_rem_s;
      quo_r  <= nxt_quo_s;
      dvs_r  <= divisor;
      cnt_r  <= 6'd1;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r <= nxt_rem_s;
      quo_r <= nxt_quo_s;
      cnt_r <= cnt_r + 6'd1;
      if (cnt_r == 6'd31) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done      = done_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/execute_muldiv_stage.sv
// Execute-stage RV32M unit plus EX/MEM output register. Plain ALU results
// pass through in one cycle; M ops stall upstream while the multiplier
// (one cycle) or the restoring divider (32 cycles) works.
module execute_muldiv_stage
  import execute_muldiv_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            is_muldiv,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic [1:0]      wb_mux,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] alu_out,
  output logic [4:0]      rd_addr_out,
  output logic            reg_write_out,
  output logic [1:0]      wb_mux_out,
  output logic [2:0]      funct3_out
);

  state_t      state_r, state_nxt_s;
  logic        accept_s, special_s, div_start_s, stall_s;
  logic [31:0] spec_q_s, spec_r_s, spec_res_s;
  logic        a_neg_s, b_neg_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_done_s;
  logic [31:0] div_q_s, div_r_s, q_fix_s, r_fix_s, div_res_s;
  logic        sgn_a_s, sgn_b_s;
  logic [63:0] a64_s, b64_s, prod_s;
  logic [31:0] mul_res_s, done_res_s;

  logic [31:0] a_r, b_r, res_r;
  logic [63:0] prod_r;
  logic [2:0]  f3_r;
  logic [4:0]  rd_r;
  logic        rw_r, q_neg_r, r_neg_r;
  logic [1:0]  wb_r;

  logic [XLEN-1:0] out_alu_s, alu_out_r;
  logic [4:0]      out_rd_s, rd_out_r;
  logic            out_rw_s, rw_out_r;
  logic [1:0]      out_wb_s, wb_out_r;
  logic [2:0]      out_f3_s, f3_out_r;

  assign accept_s = valid_in & is_muldiv;

  // Divide cases with architecturally fixed results that bypass the divider.
  always_comb begin
    if (op_b == 32'd0) begin
      special_s = 1'b1;
      spec_q_s  = RES_ALL_ONES;
      spec_r_s  = op_a;
    end else if (!funct3[0] && (op_a == RES_INT_MIN) && (op_b == RES_ALL_ONES)) begin
      special_s = 1'b1;
      spec_q_s  = RES_INT_MIN;
      spec_r_s  = 32'd0;
    end else begin
      special_s = 1'b0;
      spec_q_s  = 32'd0;
      spec_r_s  = 32'd0;
    end
    spec_res_s = funct3[1] ? spec_r_s : spec_q_s;
  end

  // Operand magnitudes for the unsigned divider (DIV/REM have funct3[0] = 0).
  assign a_neg_s = ~funct3[0] & op_a[31];
  assign b_neg_s = ~funct3[0] & op_b[31];
  assign mag_a_s = a_neg_s ? negate32(op_a) : op_a;
  assign mag_b_s = b_neg_s ? negate32(op_b) : op_b;

  muldiv_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .done      (div_done_s),
    .quotient  (div_q_s),
    .remainder (div_r_s)
  );

  // Sign fix-up: quotient negated on differing signs, remainder follows the dividend.
  assign q_fix_s   = q_neg_r ? negate32(div_q_s) : div_q_s;
  assign r_fix_s   = r_neg_r ? negate32(div_r_s) : div_r_s;
  assign div_res_s = f3_r[1] ? r_fix_s : q_fix_s;

  // 33x33 signed product realised as a 64-bit wrap-around product of sign/zero-extended operands.
  assign sgn_a_s   = (f3_r != F3_MULHU);
  assign sgn_b_s   = (f3_r == F3_MUL) || (f3_r == F3_MULH);
  assign a64_s     = {{32{sgn_a_s & a_r[31]}}, a_r};
  assign b64_s     = {{32{sgn_b_s & b_r[31]}}, b_r};
  assign prod_s    = a64_s * b64_s;
  assign mul_res_s = (f3_r == F3_MUL) ? prod_r[31:0] : prod_r[63:32];
  assign done_res_s = f3_r[2] ? res_r : mul_res_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!funct3[2]) begin
              state_nxt_s = ST_MUL;
            end else if (special_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_DIV;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL:  state_nxt_s = ST_DONE;
        ST_DIV: begin
          if (div_done_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stall, divider start and next contents of the output register (bubble by default).
  always_comb begin
    stall_s     = 1'b0;
    div_start_s = 1'b0;
    out_alu_s   = '0;
    out_rd_s    = 5'd0;
    out_rw_s    = 1'b0;
    out_wb_s    = 2'd0;
    out_f3_s    = 3'd0;
    if (flush) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            stall_s     = 1'b1;
            div_start_s = funct3[2] & ~special_s;
          end else if (valid_in) begin
            out_alu_s = alu_result;
            out_rd_s  = rd_addr;
            out_rw_s  = reg_write;
            out_wb_s  = wb_mux;
            out_f3_s  = funct3;
          end else begin
            stall_s = 1'b0;
          end
        end
        ST_MUL:  stall_s = 1'b1;
        ST_DIV:  stall_s = 1'b1;
        ST_DONE: begin
          out_alu_s = done_res_s;
          out_rd_s  = rd_r;
          out_rw_s  = rw_r;
          out_wb_s  = wb_r;
          out_f3_s  = f3_r;
        end
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Operand/control capture on accept, product in MUL, fixed-up quotient/remainder on divider done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      f3_r    <= 3'd0;
      rd_r    <= 5'd0;
      rw_r    <= 1'b0;
      wb_r    <= 2'd0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      res_r   <= 32'd0;
      prod_r  <= 64'd0;
    end else if ((state_r == ST_IDLE) && accept_s && !flush) begin
      a_r     <= op_a;
      b_r     <= op_b;
      f3_r    <= funct3;
      rd_r    <= rd_addr;
      rw_r    <= reg_write;
      wb_r    <= wb_mux;
      q_neg_r <= a_neg_s ^ b_neg_s;
      r_neg_r <= a_neg_s;
      res_r   <= spec_res_s;
    end else if (state_r == ST_MUL) begin
      prod_r <= prod_s;
    end else if ((state_r == ST_DIV) && div_done_s) begin
      res_r <= div_res_s;
    end
  end

  // EX/MEM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_r <= '0;
      rd_out_r  <= 5'd0;
      rw_out_r  <= 1'b0;
      wb_out_r  <= 2'd0;
      f3_out_r  <= 3'd0;
    end else begin
      alu_out_r <= out_alu_s;
      rd_out_r  <= out_rd_s;
      rw_out_r  <= out_rw_s;
      wb_out_r  <= out_wb_s;
      f3_out_r  <= out_f3_s;
    end
  end

  assign stall         = stall_s;
  assign alu_out       = alu_out_r;
  assign rd_addr_out   = rd_out_r;
  assign reg_write_out = rw_out_r;
  assign wb_mux_out    = wb_out_r;
  assign funct3_out    = f3_out_r;

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Self-checking bench for execute_muldiv_stage: a table of directed vectors,
// randomized vectors checked against an arithmetic RV32M model, and hand
// sequences for flush and reset in the middle of an operation.
module tb_execute_muldiv_stage;

  logic        clk = 1'b0;
  logic        rst, valid_in, is_muldiv, reg_write, flush;
  logic [31:0] alu_result, op_a, op_b;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [1:0]  wb_mux;
  logic        stall, reg_write_out;
  logic [31:0] alu_out;
  logic [4:0]  rd_addr_out;
  logic [1:0]  wb_mux_out;
  logic [2:0]  funct3_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        md;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  wb;
    logic [31:0] exp;
    int          nstall;
  } vec_t;

  vec_t vecs[13];

  execute_muldiv_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .is_muldiv     (is_muldiv),
    .alu_result    (alu_result),
    .op_a          (op_a),
    .op_b          (op_b),
    .funct3        (funct3),
    .rd_addr       (rd_addr),
    .reg_write     (reg_write),
    .wb_mux        (wb_mux),
    .flush         (flush),
    .stall         (stall),
    .alu_out       (alu_out),
    .rd_addr_out   (rd_addr_out),
    .reg_write_out (reg_write_out),
    .wb_mux_out    (wb_mux_out),
    .funct3_out    (funct3_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bubble(input string name);
    check(name, {27'd0, alu_out, rd_addr_out, reg_write_out, wb_mux_out, funct3_out}, 64'd0);
  endtask

  // RV32M result computed from the ISA definition with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Number of stalled cycles the op occupies before its unstalled DONE/pass cycle.
  function automatic int ref_stalls(input logic md, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!md) return 0;
    if (!f3[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic vec_t mk(input logic md, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] exp, input int ns);
    vec_t v;
    v.md = md; v.f3 = f3; v.a = a; v.b = b; v.alu = alu; v.rd = rd;
    v.rw = 1'b1; v.wb = 2'd1; v.exp = exp; v.nstall = ns;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      5: return $urandom_range(1, 100);
      default: return $urandom();
    endcase
  endfunction

  // Presents one instruction, holds it while stalled, checks stall each cycle,
  // bubbles on stalled edges, and the full output record on the final edge.
  task automatic run_vec(input vec_t v, input string tag);
    valid_in = 1'b1; is_muldiv = v.md; funct3 = v.f3; op_a = v.a; op_b = v.b;
    alu_result = v.alu; rd_addr = v.rd; reg_write = v.rw; wb_mux = v.wb;
    for (int c = 0; c <= v.nstall; c++) begin
      #1;
      check($sformatf("%s_stall_c%0d", tag, c), {63'd0, stall}, {63'd0, (c < v.nstall)});
      @(posedge clk); #1;
      if (c < v.nstall) begin
        check_bubble($sformatf("%s_bubble_c%0d", tag, c));
      end else begin
        check({tag, "_alu_out"}, {32'd0, alu_out}, {32'd0, v.exp});
        check({tag, "_ctrl"}, {51'd0, rd_addr_out, reg_write_out, wb_mux_out, funct3_out},
              {51'd0, v.rd, v.rw, v.wb, v.f3});
      end
    end
    valid_in = 1'b0; is_muldiv = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0; valid_in = 1'b1; is_muldiv = 1'b0;
    alu_result = 32'h55; op_a = 32'd0; op_b = 32'd0; funct3 = 3'd1;
    rd_addr = 5'd3; reg_write = 1'b1; wb_mux = 2'd2;

    // Reset dominates a valid plain op.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_bubble("reset_outputs");
    check("reset_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0; valid_in = 1'b0;
    @(posedge clk); #1;

    vecs[0]  = mk(1'b0, 3'd2, 32'd0,          32'd0,          32'h1234, 5'd5,  32'h0000_1234, 0);
    vecs[1]  = mk(1'b1, 3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,    5'd6,  32'h0000_0000, 2);
    vecs[2]  = mk(1'b1, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,    5'd7,  32'hFFFF_FFFE, 2);
    vecs[3]  = mk(1'b1, 3'd4, 32'hFFFF_FFF9,  32'd2,          32'd0,    5'd8,  32'hFFFF_FFFD, 33);
    vecs[4]  = mk(1'b1, 3'd6, 32'hFFFF_FFF9,  32'd2,          32'd0,    5'd9,  32'hFFFF_FFFF, 33);
    vecs[5]  = mk(1'b1, 3'd5, 32'd5,          32'd0,          32'd0,    5'd10, 32'hFFFF_FFFF, 1);
    vecs[6]  = mk(1'b1, 3'd7, 32'd5,          32'd0,          32'd0,    5'd11, 32'h0000_0005, 1);
    vecs[7]  = mk(1'b1, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,    5'd12, 32'h8000_0000, 1);
    vecs[8]  = mk(1'b1, 3'd0, 32'd7,          32'hFFFF_FFFD,  32'd0,    5'd13, 32'hFFFF_FFEB, 2);
    vecs[9]  = mk(1'b1, 3'd2, 32'hFFFF_FFFF,  32'd2,          32'd0,    5'd14, 32'hFFFF_FFFF, 2);
    vecs[10] = mk(1'b1, 3'd5, 32'd100,        32'd7,          32'd0,    5'd15, 32'h0000_000E, 33);
    vecs[11] = mk(1'b1, 3'd7, 32'd100,        32'd7,          32'd0,    5'd16, 32'h0000_0002, 33);
    vecs[12] = mk(1'b1, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,    5'd17, 32'h0000_0000, 1);

    // Directed table, applied back to back.
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized ops against the arithmetic model, with occasional idle cycles.
    for (int i = 0; i < 60; i++) begin
      v.md  = ($urandom_range(0, 3) != 0);
      v.f3  = 3'($urandom_range(0, 7));
      v.a   = pick();
      v.b   = pick();
      v.alu = $urandom();
      v.rd  = 5'($urandom_range(0, 31));
      v.rw  = 1'($urandom_range(0, 1));
      v.wb  = 2'($urandom_range(0, 3));
      v.exp = v.md ? ref_result(v.f3, v.a, v.b) : v.alu;
      v.nstall = ref_stalls(v.md, v.f3, v.a, v.b);
      run_vec(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check_bubble($sformatf("rnd%0d_idle", i));
      end
    end

    // Flush at cycle 10 of a DIV: stall drops, no writeback, plain op then passes.
    valid_in = 1'b1; is_muldiv = 1'b1; funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    rd_addr = 5'd20; reg_write = 1'b1; wb_mux = 2'd1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("flush_stall_c%0d", c), {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      check_bubble($sformatf("flush_bubble_c%0d", c));
    end
    flush = 1'b1;
    #1;
    check("flush_stall_drop", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check_bubble("flush_edge");
    flush = 1'b0; valid_in = 1'b0; is_muldiv = 1'b0;
    run_vec(mk(1'b0, 3'd3, 32'd0, 32'd0, 32'hCAFE_0001, 5'd21, 32'hCAFE_0001, 0), "after_flush");
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      check_bubble($sformatf("after_flush_idle%0d", c));
    end

    // Reset while in MUL: op aborted, no writeback, IDLE next.
    valid_in = 1'b1; is_muldiv = 1'b1; funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    rd_addr = 5'd22; reg_write = 1'b1; wb_mux = 2'd3;
    #1;
    check("rstmul_stall_c0", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b0; is_muldiv = 1'b0;
    @(posedge clk); #1;
    check_bubble("rstmul_outputs");
    rst = 1'b0;
    #1;
    check("rstmul_stall_after", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check_bubble("rstmul_no_writeback");
    @(posedge clk); #1;
    check_bubble("rstmul_no_writeback2");
    run_vec(mk(1'b0, 3'd0, 32'd0, 32'd0, 32'h0BAD_F00D, 5'd23, 32'h0BAD_F00D, 0), "after_rst");
    run_vec(mk(1'b1, 3'd0, 32'd6, 32'd7, 32'd0, 5'd24, 32'd42, 2), "mul_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
